gate_sweep: RTL and testbench

GATE_SWEEP -- requirements
Module: gate_sweep

---
 rtl/gate_sweep.sv | 103 ++++++++++
 tb/tb_gate_sweep.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep.sv
// Exhaustive gate characteriser: walks every N-bit input combination through a
// selectable gate, holding each for HOLD cycles, and captures the truth table.
module gate_sweep #(
  parameter int N    = 2,
  parameter int HOLD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          mode,
  output logic [N-1:0]        in_vec,
  output logic                out_bit,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   truth,
  output logic                table_valid
);

  localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N-1:0] VEC_LAST  = '1;
  localparam logic [N-1:0] VEC_ONE   = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] mode_q;
  logic [7:0] hold_cnt;

  // Reductions cover all N bits; the BUF/NOT modes look only at bit 0.
  function automatic logic gate_eval(input logic [2:0] m, input logic [N-1:0] v);
    logic r;
    r = 1'b0;
    case (m)
      3'd0: r = ~&v;
      3'd1: r = &v;
      3'd2: r = |v;
      3'd3: r = ~|v;
      3'd4: r = ^v;
      3'd5: r = ~^v;
      3'd6: r = v[0];
      3'd7: r = ~v[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign out_bit = gate_eval(mode_q, in_vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_vec      <= '0;
      hold_cnt    <= '0;
      mode_q      <= '0;
      truth       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q      <= mode;
            in_vec      <= '0;
            hold_cnt    <= '0;
            table_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= SWEEP;
          end
        end
        SWEEP: begin
          if (hold_cnt == HOLD_LAST) begin
            // Last hold cycle: record this combination and move on; in_vec
            // wraps to zero naturally after the final entry.
            hold_cnt       <= '0;
            truth[in_vec]  <= out_bit;
            in_vec         <= in_vec + VEC_ONE;
            if (in_vec == VEC_LAST) begin
              busy        <= 1'b0;
              done        <= 1'b1;
              table_valid <= 1'b1;
              state       <= DONE;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep.sv
// Bench for gate_sweep: three instances (N=2/H=1, N=3/H=2, N=1/H=1) checked
// cycle by cycle against a popcount-based truth-table model.
module tb_gate_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] mode;
  logic       st0, st1, st2;
  logic [1:0] iv0;
  logic [2:0] iv1;
  logic [0:0] iv2;
  logic       ob0, ob1, ob2, bz0, bz1, bz2, dn0, dn1, dn2, tv0, tv1, tv2;
  logic [3:0] tr0;
  logic [7:0] tr1;
  logic [1:0] tr2;

  int checks = 0;
  int errors = 0;
  logic [63:0] tbl [3];

  gate_sweep #(.N(2), .HOLD(1)) u0 (
    .clk(clk), .reset(reset), .start(st0), .mode(mode), .in_vec(iv0), .out_bit(ob0),
    .busy(bz0), .done(dn0), .truth(tr0), .table_valid(tv0));
  gate_sweep #(.N(3), .HOLD(2)) u1 (
    .clk(clk), .reset(reset), .start(st1), .mode(mode), .in_vec(iv1), .out_bit(ob1),
    .busy(bz1), .done(dn1), .truth(tr1), .table_valid(tv1));
  gate_sweep #(.N(1), .HOLD(1)) u2 (
    .clk(clk), .reset(reset), .start(st2), .mode(mode), .in_vec(iv2), .out_bit(ob2),
    .busy(bz2), .done(dn2), .truth(tr2), .table_valid(tv2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int s);
    case (s)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int h_of(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic logic ref_gate(input int m, input int v, input int n);
    int pc;
    pc = 0;
    for (int b = 0; b < n; b++) pc += (v >> b) & 1;
    case (m)
      0: return !(pc == n);
      1: return pc == n;
      2: return pc != 0;
      3: return pc == 0;
      4: return (pc % 2) == 1;
      5: return (pc % 2) == 0;
      6: return (v & 1) == 1;
      default: return (v & 1) == 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_table(input int m, input int n);
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < (1 << n); i++) t[i] = ref_gate(m, i, n);
    return t;
  endfunction

  function automatic logic [63:0] o_vec(input int s);
    case (s)
      0: return 64'(iv0);
      1: return 64'(iv1);
      default: return 64'(iv2);
    endcase
  endfunction

  function automatic logic [63:0] o_truth(input int s);
    case (s)
      0: return 64'(tr0);
      1: return 64'(tr1);
      default: return 64'(tr2);
    endcase
  endfunction

  function automatic logic [63:0] o_bit(input int s, input int which);
    logic [2:0] v;
    case (s)
      0: v = {ob0, bz0, dn0};
      1: v = {ob1, bz1, dn1};
      default: v = {ob2, bz2, dn2};
    endcase
    if (which == 3) return 64'((s == 0) ? tv0 : (s == 1) ? tv1 : tv2);
    return 64'(v[which]);
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("%s busy%0d", tag, s), o_bit(s, 1), 64'd0);
      chk($sformatf("%s done%0d", tag, s), o_bit(s, 0), 64'd0);
      chk($sformatf("%s tv%0d", tag, s), o_bit(s, 3), 64'd0);
      chk($sformatf("%s vec%0d", tag, s), o_vec(s), 64'd0);
      chk($sformatf("%s truth%0d", tag, s), o_truth(s), 64'd0);
      chk($sformatf("%s out%0d", tag, s), o_bit(s, 2), 64'd1);
      tbl[s] = '0;
    end
  endtask

  // abort_at >= 0 pulses reset on that sweep cycle instead of finishing.
  task automatic run_sweep(input int s, input int m, input bit noise,
                           input bit hold_next, input int next_m, input int abort_at);
    int n, h, total, idx;
    logic [63:0] newt, lowmask;
    n = n_of(s);
    h = h_of(s);
    total = (1 << n) * h;
    newt = ref_table(m, n);
    set_start(s, 1'b1);
    mode = 3'(m);
    step();
    set_start(s, 1'b0);
    for (int k = 0; k < total; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("abort");
        return;
      end
      idx = k / h;
      lowmask = (64'd1 << idx) - 64'd1;
      chk($sformatf("s%0d m%0d k%0d busy", s, m, k), o_bit(s, 1), 64'd1);
      chk($sformatf("s%0d m%0d k%0d done", s, m, k), o_bit(s, 0), 64'd0);
      chk($sformatf("s%0d m%0d k%0d vec", s, m, k), o_vec(s), 64'(idx));
      chk($sformatf("s%0d m%0d k%0d out", s, m, k), o_bit(s, 2), 64'(ref_gate(m, idx, n)));
      chk($sformatf("s%0d m%0d k%0d tv", s, m, k), o_bit(s, 3), 64'd0);
      chk($sformatf("s%0d m%0d k%0d truth", s, m, k), o_truth(s),
          (newt & lowmask) | (tbl[s] & ~lowmask));
      if (noise) begin
        set_start(s, 1'($urandom % 2));
        mode = 3'($urandom);
      end
      step();
    end
    chk($sformatf("s%0d m%0d done", s, m), o_bit(s, 0), 64'd1);
    chk($sformatf("s%0d m%0d done busy", s, m), o_bit(s, 1), 64'd0);
    chk($sformatf("s%0d m%0d done tv", s, m), o_bit(s, 3), 64'd1);
    chk($sformatf("s%0d m%0d done vec", s, m), o_vec(s), 64'd0);
    chk($sformatf("s%0d m%0d table", s, m), o_truth(s), newt);
    tbl[s] = newt;
    set_start(s, hold_next);
    mode = 3'(next_m);
    step();
    chk($sformatf("s%0d m%0d idle done", s, m), o_bit(s, 0), 64'd0);
    chk($sformatf("s%0d m%0d idle busy", s, m), o_bit(s, 1), 64'd0);
    chk($sformatf("s%0d m%0d idle tv", s, m), o_bit(s, 3), 64'd1);
    chk($sformatf("s%0d m%0d idle out", s, m), o_bit(s, 2), 64'(ref_gate(m, 0, n)));
  endtask

  initial begin
    int s, m, gap;
    reset = 1'b1;
    mode = 3'd0;
    st0 = 1'b0;
    st1 = 1'b0;
    st2 = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check_reset_state("reset");

    run_sweep(0, 0, 1'b0, 1'b0, 0, -1);
    chk("nand2 literal", 64'(tr0), 64'h7);
    run_sweep(1, 4, 1'b0, 1'b0, 0, -1);
    chk("xor3 literal", 64'(tr1), 64'h96);
    run_sweep(0, 2, 1'b0, 1'b1, 2, -1);
    chk("or2 literal", 64'(tr0), 64'he);
    mode = 3'd3;
    run_sweep(0, 3, 1'b0, 1'b0, 0, -1);
    chk("nor2 literal", 64'(tr0), 64'h1);
    run_sweep(0, 0, 1'b1, 1'b0, 0, -1);
    chk("nand2 noisy literal", 64'(tr0), 64'h7);
    run_sweep(1, 0, 1'b0, 1'b0, 0, 2);
    run_sweep(1, 1, 1'b0, 1'b0, 0, -1);
    chk("and3 literal", 64'(tr1), 64'h80);
    run_sweep(2, 6, 1'b0, 1'b0, 0, -1);
    chk("buf1 literal", 64'(tr2), 64'h2);
    run_sweep(2, 7, 1'b0, 1'b0, 0, -1);
    chk("not1 literal", 64'(tr2), 64'h1);

    for (int r = 0; r < 12; r++) begin
      s = int'($urandom % 3);
      m = int'($urandom % 8);
      gap = int'($urandom % 4);
      for (int g = 0; g < gap; g++) step();
      run_sweep(s, m, 1'($urandom % 2), 1'b0, m, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
